// File: rtl/junction_light_ctrl_pkg.sv
// Shared definitions for the junction light controller: lamp encodings,
// phase codes and the phase-code width.
package junction_light_ctrl_pkg;

    localparam int PHASE_W = 3;

    // One-hot lamp encoding, bit 0 = red, bit 1 = green, bit 2 = yellow
    localparam logic [0:2] LAMP_RED    = 3'b100;
    localparam logic [0:2] LAMP_GREEN  = 3'b010;
    localparam logic [0:2] LAMP_YELLOW = 3'b001;

    // Phase codes; 6 and 7 are unused and recovered to MAIN_G
    typedef enum logic [PHASE_W-1:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        RED_A  = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4,
        RED_B  = 3'd5
    } state_t;

endpackage

// File: rtl/junction_light_ctrl_phase_timer.sv
// Loadable down-counter that measures phase durations in timebase ticks.
// A load wins over counting; counting stops at zero until the next load.
module junction_light_ctrl_phase_timer #(
    parameter int                CNT_W     = 8,
    parameter logic [CNT_W-1:0]  RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick_en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    // Load a new duration, or count down one step per tick while non-zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= RESET_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick_en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/junction_light_ctrl.sv
// Two-road junction controller: sequences main and side lamps through
// green/yellow/all-red phases, serves side-road and pedestrian demand and
// drives the pedestrian walk lamp. All timing is in ticks of tick_en.
module junction_light_ctrl
    import junction_light_ctrl_pkg::*;
#(
    parameter int GREEN_TICKS  = 4,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int CNT_W        = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick_en,
    input  logic               side_req,
    input  logic               ped_req,
    output logic [0:2]         main_light,
    output logic [0:2]         side_light,
    output logic               walk,
    output logic [PHASE_W-1:0] phase
);

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TICKS - 1);

    state_t           state_reg;
    state_t           state_next;
    logic             ped_pend_reg;
    logic             walk_grant_reg;
    logic             timer_load;
    logic [CNT_W-1:0] timer_load_val;
    logic [CNT_W-1:0] timer_cnt;
    logic             timer_zero;
    logic             advance;
    logic             start_side_g;

    junction_light_ctrl_phase_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL (GREEN_LD)
    ) u_phase_timer (
        .clock    (clock),
        .reset    (reset),
        .tick_en  (tick_en),
        .load     (timer_load),
        .load_val (timer_load_val),
        .cnt      (timer_cnt),
        .zero     (timer_zero)
    );

    // A phase may only end on a tick where its timer has already run out
    assign advance = tick_en && timer_zero;

    // Next-phase selection and the matching timer reload
    always_comb begin
        state_next     = state_reg;
        timer_load     = 1'b0;
        timer_load_val = GREEN_LD;
        case (state_reg)
            MAIN_G: begin
                // Main green is the rest state: leave only when someone is waiting
                if (advance && (side_req || ped_pend_reg)) begin
                    state_next     = MAIN_Y;
                    timer_load     = 1'b1;
                    timer_load_val = YELLOW_LD;
                end
            end
            MAIN_Y: begin
                if (advance) begin
                    state_next     = RED_A;
                    timer_load     = 1'b1;
                    timer_load_val = ALLRED_LD;
                end
            end
            RED_A: begin
                if (advance) begin
                    state_next     = SIDE_G;
                    timer_load     = 1'b1;
                    timer_load_val = GREEN_LD;
                end
            end
            SIDE_G: begin
                if (advance) begin
                    state_next     = SIDE_Y;
                    timer_load     = 1'b1;
                    timer_load_val = YELLOW_LD;
                end
            end
            SIDE_Y: begin
                if (advance) begin
                    state_next     = RED_B;
                    timer_load     = 1'b1;
                    timer_load_val = ALLRED_LD;
                end
            end
            RED_B: begin
                if (advance) begin
                    state_next     = MAIN_G;
                    timer_load     = 1'b1;
                    timer_load_val = GREEN_LD;
                end
            end
            default: begin
                // Corrupted phase code: recover at once, regardless of tick_en
                state_next     = MAIN_G;
                timer_load     = 1'b1;
                timer_load_val = GREEN_LD;
            end
        endcase
    end

    assign start_side_g = (state_reg == RED_A) && (state_next == SIDE_G);

    // Phase register plus pedestrian request latch and walk grant
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= MAIN_G;
            ped_pend_reg   <= 1'b0;
            walk_grant_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_side_g) begin
                // A press on this very cycle is folded into the grant being issued
                walk_grant_reg <= ped_pend_reg || ped_req;
                ped_pend_reg   <= 1'b0;
            end else begin
                if (ped_req) begin
                    ped_pend_reg <= 1'b1;
                end
                if (state_next != SIDE_G) begin
                    walk_grant_reg <= 1'b0;
                end
            end
        end
    end

    // Moore lamp decode from the phase register; unknown codes show all red
    always_comb begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
        case (state_reg)
            MAIN_G: main_light = LAMP_GREEN;
            MAIN_Y: main_light = LAMP_YELLOW;
            SIDE_G: side_light = LAMP_GREEN;
            SIDE_Y: side_light = LAMP_YELLOW;
            default: begin
                main_light = LAMP_RED;
                side_light = LAMP_RED;
            end
        endcase
    end

    assign walk  = walk_grant_reg && (state_reg == SIDE_G);
    assign phase = state_reg;

endmodule

// File: tb/tb_junction_light_ctrl.sv
// Directed testbench for junction_light_ctrl with default timing
// (green 4, yellow 2, all-red 1 ticks).
module tb_junction_light_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick_en;
    logic       side_req;
    logic       ped_req;
    logic [0:2] main_light;
    logic [0:2] side_light;
    logic       walk;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;

    junction_light_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .tick_en    (tick_en),
        .side_req   (side_req),
        .ped_req    (ped_req),
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk),
        .phase      (phase)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    // Compare all outputs against the hand-written lamp table for a phase
    task automatic check_state(input string tag, input logic [2:0] ph, input logic wk);
        logic [2:0] em;
        logic [2:0] es;
        case (ph)
            3'd0:    begin em = 3'b010; es = 3'b100; end
            3'd1:    begin em = 3'b001; es = 3'b100; end
            3'd3:    begin em = 3'b100; es = 3'b010; end
            3'd4:    begin em = 3'b100; es = 3'b001; end
            default: begin em = 3'b100; es = 3'b100; end
        endcase
        chk({tag, "_phase"}, phase, ph);
        chk({tag, "_main"}, main_light, em);
        chk({tag, "_side"}, side_light, es);
        chk({tag, "_walk"}, {2'b00, walk}, {2'b00, wk});
    endtask

    task automatic tick_step();
        @(posedge clock);
        #1;
    endtask

    // Expect n consecutive cycles in one phase; optionally alternate tick_en
    task automatic expect_run(input string tag, input int n, input logic [2:0] ph,
                              input logic wk, input bit toggle);
        for (int i = 0; i < n; i++) begin
            if (toggle) tick_en = ~tick_en;
            check_state(tag, ph, wk);
            tick_step();
        end
    endtask

    initial begin
        reset    = 1'b1;
        tick_en  = 1'b1;
        side_req = 1'b1;
        ped_req  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_state("reset0", 3'd0, 1'b0);
        reset = 1'b0;

        // Continuous side demand: 14-cycle cycle, no walk
        for (int lap = 0; lap < 2; lap++) begin
            expect_run("t2_main_g", 4, 3'd0, 1'b0, 1'b0);
            expect_run("t2_main_y", 2, 3'd1, 1'b0, 1'b0);
            expect_run("t2_red_a",  1, 3'd2, 1'b0, 1'b0);
            expect_run("t2_side_g", 4, 3'd3, 1'b0, 1'b0);
            expect_run("t2_side_y", 2, 3'd4, 1'b0, 1'b0);
            expect_run("t2_red_b",  1, 3'd5, 1'b0, 1'b0);
        end

        // Asynchronous reset mid-cycle, then idle
        side_req = 1'b0;
        reset    = 1'b1;
        #1;
        check_state("reset1", 3'd0, 1'b0);
        tick_step();
        reset = 1'b0;
        expect_run("t1_idle", 50, 3'd0, 1'b0, 1'b0);

        // Single-cycle pedestrian press at main green cnt==0
        ped_req = 1'b1;
        check_state("t3_press", 3'd0, 1'b0);
        tick_step();
        ped_req = 1'b0;
        check_state("t3_pend", 3'd0, 1'b0);
        tick_step();
        expect_run("t3_main_y", 2, 3'd1, 1'b0, 1'b0);
        expect_run("t3_red_a",  1, 3'd2, 1'b0, 1'b0);
        expect_run("t3_side_g", 4, 3'd3, 1'b1, 1'b0);
        expect_run("t3_side_y", 2, 3'd4, 1'b0, 1'b0);
        expect_run("t3_red_b",  1, 3'd5, 1'b0, 1'b0);
        expect_run("t3_rest",  20, 3'd0, 1'b0, 1'b0);

        // Pedestrian press exactly on the RED_A -> SIDE_G edge
        side_req = 1'b1;
        check_state("t4_req", 3'd0, 1'b0);
        tick_step();
        side_req = 1'b0;
        expect_run("t4_main_y", 2, 3'd1, 1'b0, 1'b0);
        ped_req = 1'b1;
        check_state("t4_red_a", 3'd2, 1'b0);
        tick_step();
        ped_req = 1'b0;
        expect_run("t4_side_g", 4, 3'd3, 1'b1, 1'b0);
        expect_run("t4_side_y", 2, 3'd4, 1'b0, 1'b0);
        expect_run("t4_red_b",  1, 3'd5, 1'b0, 1'b0);
        expect_run("t4_rest",  15, 3'd0, 1'b0, 1'b0);

        // Half-rate timebase; press lands on a tick_en=0 cycle
        tick_en = 1'b0;
        ped_req = 1'b1;
        check_state("t5_press", 3'd0, 1'b0);
        tick_step();
        ped_req = 1'b0;
        tick_en = 1'b1;
        check_state("t5_pend", 3'd0, 1'b0);
        tick_step();
        expect_run("t5_main_y", 4, 3'd1, 1'b0, 1'b1);
        expect_run("t5_red_a",  2, 3'd2, 1'b0, 1'b1);
        expect_run("t5_side_g", 8, 3'd3, 1'b1, 1'b1);
        expect_run("t5_side_y", 4, 3'd4, 1'b0, 1'b1);
        expect_run("t5_red_b",  2, 3'd5, 1'b0, 1'b1);
        expect_run("t5_rest",  10, 3'd0, 1'b0, 1'b1);
        tick_en = 1'b1;

        // Reset during SIDE_G with a fresh pedestrian request pending
        ped_req = 1'b1;
        check_state("t6_press", 3'd0, 1'b0);
        tick_step();
        ped_req = 1'b0;
        check_state("t6_pend", 3'd0, 1'b0);
        tick_step();
        expect_run("t6_main_y", 2, 3'd1, 1'b0, 1'b0);
        expect_run("t6_red_a",  1, 3'd2, 1'b0, 1'b0);
        expect_run("t6_side_g", 2, 3'd3, 1'b1, 1'b0);
        ped_req = 1'b1;
        tick_step();
        ped_req = 1'b0;
        check_state("t6_side_g3", 3'd3, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_state("t6_reset", 3'd0, 1'b0);
        tick_step();
        reset = 1'b0;
        expect_run("t6_rest", 20, 3'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
